// File: rtl/seg_mem1_pkg.sv
// seg_mem1 shared encodings, bus widths and bus layouts.
// Provides the op/alusel codes, size codes and the primary/secondary bus structs.
package seg_mem1_pkg;

    localparam logic RstEnable = 1'b1;

    localparam int BUS_PRI_W = 146;
    localparam int BUS_SEC_W = 70;

    localparam logic [3:0] LOAD  = 4'd6;
    localparam logic [3:0] STORE = 4'd7;

    localparam logic [7:0] LB_OP  = 8'hE0;
    localparam logic [7:0] LH_OP  = 8'hE1;
    localparam logic [7:0] LWL_OP = 8'hE2;
    localparam logic [7:0] LW_OP  = 8'hE3;
    localparam logic [7:0] LBU_OP = 8'hE4;
    localparam logic [7:0] LHU_OP = 8'hE5;
    localparam logic [7:0] LWR_OP = 8'hE6;
    localparam logic [7:0] SB_OP  = 8'hE8;
    localparam logic [7:0] SH_OP  = 8'hE9;
    localparam logic [7:0] SWL_OP = 8'hEA;
    localparam logic [7:0] SW_OP  = 8'hEB;
    localparam logic [7:0] SWR_OP = 8'hEE;
    localparam logic [7:0] LL_OP  = 8'hF0;
    localparam logic [7:0] SC_OP  = 8'hF8;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef struct packed {
        logic [31:0] opdata2;
        logic [31:0] mem_addr;
        logic [7:0]  aluop;
        logic [3:0]  alusel;
        logic [31:0] reg_wdata;
        logic [4:0]  reg_waddr;
        logic        reg_write;
        logic [31:0] inst_addr;
    } pri_bus_t;

    typedef struct packed {
        logic [31:0] reg_wdata;
        logic [4:0]  reg_waddr;
        logic        reg_write;
        logic [31:0] inst_addr;
    } sec_bus_t;

endpackage

// File: rtl/seg_mem1_if.sv
// Data-SRAM address-phase bus between seg_mem1 (master) and the SRAM (slave).
// req/wr/size/wstrb/addr/wdata flow to the SRAM; addr_ok flows back.
interface seg_mem1_if;

    logic        data_req_o;
    logic        data_wr_o;
    logic [1:0]  data_size_o;
    logic [3:0]  data_wstrb_o;
    logic [31:0] data_addr_o;
    logic [31:0] data_wdata_o;
    logic        data_addr_ok_i;

    modport master (
        output data_req_o, data_wr_o, data_size_o,
        output data_wstrb_o, data_addr_o, data_wdata_o,
        input  data_addr_ok_i
    );

    modport slave (
        input  data_req_o, data_wr_o, data_size_o,
        input  data_wstrb_o, data_addr_o, data_wdata_o,
        output data_addr_ok_i
    );

endinterface

// File: rtl/mem_store_align.sv
// Combinational size/strobe/data/address alignment for memory ops.
// In: aluop_i, mem_addr_i, rt_i. Out: size_o, wstrb_o, wdata_o, addr_o.
module mem_store_align
    import seg_mem1_pkg::*;
(
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] rt_i,
    output logic [1:0]  size_o,
    output logic [3:0]  wstrb_o,
    output logic [31:0] wdata_o,
    output logic [31:0] addr_o
);

    logic [1:0] k;
    logic [4:0] sh_up;
    logic [4:0] sh_dn;

    assign k     = mem_addr_i[1:0];
    assign sh_up = {k, 3'b000};
    assign sh_dn = {2'd3 - k, 3'b000};

    always_comb begin
        size_o  = SIZE_B;
        wstrb_o = 4'b0000;
        wdata_o = 32'h0;
        addr_o  = mem_addr_i;
        case (aluop_i)
            LB_OP, LBU_OP: begin
                size_o  = SIZE_B;
                wdata_o = {4{rt_i[7:0]}};
            end
            SB_OP: begin
                size_o  = SIZE_B;
                wstrb_o = 4'b0001 << k;
                wdata_o = {4{rt_i[7:0]}};
            end
            LH_OP, LHU_OP: begin
                size_o  = SIZE_H;
                wdata_o = {2{rt_i[15:0]}};
            end
            SH_OP: begin
                size_o  = SIZE_H;
                wstrb_o = 4'b0011 << k;
                wdata_o = {2{rt_i[15:0]}};
            end
            LW_OP, LL_OP: begin
                size_o  = SIZE_W;
                wdata_o = rt_i;
            end
            SW_OP, SC_OP: begin
                size_o  = SIZE_W;
                wstrb_o = 4'b1111;
                wdata_o = rt_i;
            end
            LWL_OP, LWR_OP: begin
                size_o  = SIZE_W;
                wdata_o = rt_i;
                addr_o  = {mem_addr_i[31:2], 2'b00};
            end
            SWL_OP: begin
                // k=3 wraps 2<<3 to zero, so the minus one gives 1111
                size_o  = SIZE_W;
                wstrb_o = (4'd2 << k) - 4'd1;
                wdata_o = rt_i >> sh_dn;
                addr_o  = {mem_addr_i[31:2], 2'b00};
            end
            SWR_OP: begin
                size_o  = SIZE_W;
                wstrb_o = 4'b1111 << k;
                wdata_o = rt_i << sh_up;
                addr_o  = {mem_addr_i[31:2], 2'b00};
            end
            default: begin
                size_o  = SIZE_B;
            end
        endcase
    end

endmodule

// File: rtl/seg_mem1.sv
// First memory stage: holds one pri/sec pair, issues the SRAM address phase, owns LL/SC link.
// Ports: clk/rst, EX-side valid+buses, MEM2-side allowin/valid/buses, flush, llbit clear,
// dbus (SRAM address phase), allowin to EX, bypass and up-bus to the hazard/forward logic.
module seg_mem1
    import seg_mem1_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ex_mem1_valid_i,
    input  logic [BUS_PRI_W-1:0] ex_mem1_bus_primary_i,
    input  logic [BUS_SEC_W-1:0] ex_mem1_bus_secondary_i,
    input  logic                 mem2_allowin_i,
    input  logic                 flush_i,
    input  logic                 llbit_clear_i,
    seg_mem1_if.master           dbus,
    output logic                 mem1_allowin_o,
    output logic                 mem1_mem2_valid_o,
    output logic [BUS_PRI_W-1:0] mem1_mem2_bus_primary_o,
    output logic [BUS_SEC_W-1:0] mem1_mem2_bus_secondary_o,
    output logic [75:0]          mem1_bypass_o,
    output logic [5:0]           mem1_up_bus_o
);

    logic     valid_q, valid_d;
    logic     llbit_q, llbit_d;
    pri_bus_t pri_q, pri_d;
    sec_bus_t sec_q, sec_d;
    pri_bus_t pri_out;

    logic is_load, is_store, is_sc, is_ll, is_mem;
    logic req, ready_go, allowin, valid_out, xfer;

    logic [1:0]  al_size;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_addr;

    assign is_load  = (pri_q.alusel == LOAD);
    assign is_store = (pri_q.alusel == STORE);
    assign is_sc    = is_store && (pri_q.aluop == SC_OP);
    assign is_ll    = is_load && (pri_q.aluop == LL_OP);
    // a failed SC touches no memory and just carries its 0 result
    assign is_mem   = is_load || (is_store && !is_sc) || (is_sc && llbit_q);

    // never request while MEM2 is blocked, so data_ok cannot land here
    assign req       = valid_q && is_mem && mem2_allowin_i && !flush_i;
    assign ready_go  = !is_mem || (req && dbus.data_addr_ok_i);
    assign allowin   = !valid_q || (ready_go && mem2_allowin_i);
    assign valid_out = valid_q && ready_go && !flush_i;
    assign xfer      = valid_out && mem2_allowin_i;

    mem_store_align u_align (
        .aluop_i    (pri_q.aluop),
        .mem_addr_i (pri_q.mem_addr),
        .rt_i       (pri_q.opdata2),
        .size_o     (al_size),
        .wstrb_o    (al_wstrb),
        .wdata_o    (al_wdata),
        .addr_o     (al_addr)
    );

    always_comb begin
        valid_d = valid_q;
        llbit_d = llbit_q;
        pri_d   = pri_q;
        sec_d   = sec_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (allowin) begin
            valid_d = ex_mem1_valid_i;
        end
        if (allowin && ex_mem1_valid_i) begin
            pri_d = ex_mem1_bus_primary_i;
            sec_d = ex_mem1_bus_secondary_i;
        end
        if (xfer && is_sc) begin
            llbit_d = 1'b0;
        end
        if (llbit_clear_i) begin
            llbit_d = 1'b0;
        end
        // an LL leaving in the same cycle as a clear still sets the link
        if (xfer && is_ll) begin
            llbit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst == RstEnable) begin
            valid_q <= 1'b0;
            llbit_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            llbit_q <= llbit_d;
        end
    end

    always_ff @(posedge clk) begin
        pri_q <= pri_d;
        sec_q <= sec_d;
    end

    always_comb begin
        pri_out = pri_q;
        if (is_sc) begin
            pri_out.reg_wdata = {31'b0, llbit_q};
        end
    end

    assign mem1_allowin_o    = allowin;
    assign mem1_mem2_valid_o = valid_out;

    assign mem1_mem2_bus_primary_o   = valid_q ? pri_out : '0;
    assign mem1_mem2_bus_secondary_o = valid_q ? sec_q : '0;

    assign dbus.data_req_o   = req;
    assign dbus.data_wr_o    = valid_q && is_store;
    assign dbus.data_size_o  = valid_q ? al_size : 2'd0;
    assign dbus.data_wstrb_o = (valid_q && is_store) ? al_wstrb : 4'd0;
    assign dbus.data_addr_o  = valid_q ? al_addr : 32'h0;
    assign dbus.data_wdata_o = valid_q ? al_wdata : 32'h0;

    assign mem1_bypass_o = valid_q ?
        {sec_q.reg_wdata, sec_q.reg_waddr, sec_q.reg_write,
         pri_out.reg_wdata, pri_q.reg_waddr, pri_q.reg_write} : '0;

    assign mem1_up_bus_o = valid_q ? {pri_q.reg_waddr, is_load} : '0;

endmodule
